// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings for the integer functional unit.
//   - unit select codes (ALU / MUL / DIV / reserved)
//   - ALU operation codes (aluctl)
//   - multiply / divide sub-operation codes (mdctl)
//   - FSM state enum for ifu_exec
//   - divider phase lengths that do not depend on XLEN
package ifu_pkg;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;
    localparam logic [1:0] UNIT_RSV = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] MD_MUL    = 2'd0;
    localparam logic [1:0] MD_MULH   = 2'd1;
    localparam logic [1:0] MD_MULHSU = 2'd2;
    localparam logic [1:0] MD_MULHU  = 2'd3;

    localparam logic [1:0] MD_DIV  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REM  = 2'd2;
    localparam logic [1:0] MD_REMU = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } ifu_state_e;

    // Divider latency = DIV_SETUP + XLEN iterations + DIV_FIX.
    localparam int DIV_SETUP = 1;
    localparam int DIV_FIX   = 1;

endpackage

// File: rtl/ifu_exec_qru.sv
// qru_radix2: iterative radix-2 restoring divider (quotient / remainder unit).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        load operands (setup happens in the start cycle)
//   sgn          1 = signed operands
//   rem_sel      1 = return remainder, 0 = quotient
//   dividend     XLEN dividend
//   divisor      XLEN divisor
//   result       sign-corrected quotient or remainder, valid while done=1
//   done         one-cycle pulse in the sign-fix cycle
// Timing: start in cycle 0, XLEN iterations in cycles 1..XLEN, done in XLEN+1.
module qru_radix2
    import ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sgn,
    input  logic            rem_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result,
    output logic            done
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, fix_q, neg_quo_q, neg_rem_q, rsel_q;

    logic            dvd_neg, dvs_neg;
    logic [XLEN-1:0] dvd_mag, dvs_mag;
    logic [XLEN:0]   shifted, diff;
    logic            ge;

    always_comb begin
        dvd_neg = sgn & dividend[XLEN-1];
        dvs_neg = sgn & divisor[XLEN-1];
        dvd_mag = dvd_neg ? (-dividend) : dividend;
        dvs_mag = dvs_neg ? (-divisor) : divisor;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = (shifted >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            fix_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rsel_q    <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            cnt_q     <= CW'(XLEN - 1);
            busy_q    <= 1'b1;
            fix_q     <= 1'b0;
            // Divide by zero must leave the all-ones quotient untouched.
            neg_quo_q <= (dvd_neg ^ dvs_neg) & (divisor != '0);
            neg_rem_q <= dvd_neg;
            rsel_q    <= rem_sel;
        end else if (busy_q) begin
            rem_q <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                fix_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end else begin
            fix_q <= 1'b0;
        end
    end

    // Magnitude min/-1 yields 2^(XLEN-1) with no negation, i.e. min itself.
    assign result = rsel_q ? (neg_rem_q ? (-rem_q) : rem_q)
                           : (neg_quo_q ? (-quo_q) : quo_q);
    assign done   = fix_q;

endmodule

// File: rtl/ifu_exec.sv
// ifu_exec: integer functional unit for the execute stage.
// ALU (1 cycle), multiply (MUL_LAT cycles) and optional radix-2 divide
// (XLEN+2 cycles) behind one valid/ready handshake with tag passthrough,
// flush and a held output register.
// Build option: define IFU_DIV_EN to include the divider; otherwise unit==2
// is treated as illegal (1 cycle, result 0, err 1).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 abort in-flight op, drop held result
//   in_valid / in_ready   operation handshake
//   unit, aluctl, mdctl   operation select
//   bsel                  ALU B operand: 1=op_b, 0=imm
//   op_a, op_b, imm       operands
//   tag_in / tag_out      destination register tag
//   out_valid / out_ready result handshake
//   result, zero, err     result, result==0, illegal-op flag
//
// state   | meaning
// IDLE    | ready to accept an operation
// MUL     | multiply latency countdown
// DIV     | divider running
// DONE    | result presented, held until out_ready
module ifu_exec
    import ifu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAGW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      unit,
    input  logic [3:0]      aluctl,
    input  logic [1:0]      mdctl,
    input  logic            bsel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] imm,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out,
    output logic            zero,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);
    localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCW-1:0] MUL_CNT_INIT = MCW'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    ifu_state_e      state_q, state_d;
    logic            accept;

    logic [XLEN-1:0] a_q, b_q;
    logic [1:0]      md_q;
    logic [TAGW-1:0] tag_q;
    logic [MCW-1:0]  mul_cnt_q;

    logic [XLEN-1:0] alu_b, alu_res;
    logic [SHW-1:0]  shamt;

    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic [1:0]        mul_md;
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] mul_prod;

    logic            ld, ld_err;
    logic [XLEN-1:0] ld_res;
    logic [TAGW-1:0] ld_tag;

`ifdef IFU_DIV_EN
    logic            q_start, q_done;
    logic [XLEN-1:0] q_res;

    assign q_start = accept && (unit == UNIT_DIV);

    qru_radix2 #(.XLEN(XLEN)) u_qru (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (q_start),
        .sgn      (~mdctl[0]),
        .rem_sel  (mdctl[1]),
        .dividend (op_a),
        .divisor  (op_b),
        .result   (q_res),
        .done     (q_done)
    );
`endif

    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    // ALU works straight off the input operands: it completes at accept.
    always_comb begin
        alu_b   = bsel ? op_b : imm;
        shamt   = alu_b[SHW-1:0];
        alu_res = '0;
        case (aluctl)
            ALU_ADD:  alu_res = op_a + alu_b;
            ALU_SUB:  alu_res = op_a - alu_b;
            ALU_AND:  alu_res = op_a & alu_b;
            ALU_OR:   alu_res = op_a | alu_b;
            ALU_XOR:  alu_res = op_a ^ alu_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < alu_b)};
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    // One multiplier shared by the MUL_LAT==1 path (live inputs) and the
    // countdown path (captured operands). Sign extension to 2*XLEN makes a
    // single unsigned multiply cover all four variants.
    always_comb begin
        mul_a    = (state_q == ST_IDLE) ? op_a  : a_q;
        mul_b    = (state_q == ST_IDLE) ? op_b  : b_q;
        mul_md   = (state_q == ST_IDLE) ? mdctl : md_q;
        a_sx     = (mul_md != MD_MULHU) & mul_a[XLEN-1];
        b_sx     = (mul_md == MD_MULH)  & mul_b[XLEN-1];
        mul_prod = {{XLEN{a_sx}}, mul_a} * {{XLEN{b_sx}}, mul_b};
        mul_res  = (mul_md == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_err  = 1'b0;
        ld_res  = '0;
        ld_tag  = tag_q;
        case (state_q)
            ST_IDLE: begin
                ld_tag = tag_in;
                if (accept) begin
                    case (unit)
                        UNIT_ALU: begin
                            ld      = 1'b1;
                            ld_res  = alu_res;
                            state_d = ST_DONE;
                        end
                        UNIT_MUL: begin
                            if (MUL_LAT == 1) begin
                                ld      = 1'b1;
                                ld_res  = mul_res;
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_MUL;
                            end
                        end
`ifdef IFU_DIV_EN
                        UNIT_DIV: state_d = ST_DIV;
`endif
                        default: begin
                            ld      = 1'b1;
                            ld_err  = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == '0) begin
                    ld      = 1'b1;
                    ld_res  = mul_res;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
`ifdef IFU_DIV_EN
                if (q_done) begin
                    ld      = 1'b1;
                    ld_res  = q_res;
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            ld      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            md_q      <= '0;
            tag_q     <= '0;
            mul_cnt_q <= '0;
            result    <= '0;
            tag_out   <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                a_q       <= op_a;
                b_q       <= op_b;
                md_q      <= mdctl;
                tag_q     <= tag_in;
                mul_cnt_q <= MUL_CNT_INIT;
            end else if ((state_q == ST_MUL) && (mul_cnt_q != '0)) begin
                mul_cnt_q <= mul_cnt_q - MCW'(1);
            end
            if (ld) begin
                result  <= ld_res;
                tag_out <= ld_tag;
                zero    <= (ld_res == '0);
                err     <= ld_err;
            end
        end
    end

endmodule
